// File: rtl/nodf_mon_pkg.sv
// Shared types, defaults and the saturating-increment helper for the
// non-dataflow HLS block activity monitor.
package nodf_mon_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        DONE_WAIT = 2'd2
    } mon_state_t;

    localparam int CNT_W_DEF = 32;

    // Increment v by one unless it has already reached max_v.
    // Callers zero-extend their counter into 64 bits and pass the all-ones
    // value of their own width as max_v, so one helper serves any CNT_W <= 64.
    function automatic logic [63:0] sat_inc(input logic [63:0] v,
                                            input logic [63:0] max_v);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter: synchronous clear, count enable, sticks at all-ones.
module nodf_sat_counter
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

    // Clear has priority; otherwise count up on enable without wrapping.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= CNT_W'(sat_inc(64'(count), CNT_MAX));
        end
    end

endmodule

// File: rtl/nodf_module_intf.sv
// Activity monitor for one non-dataflow HLS block. Tracks the transaction
// FSM, counts starts/retires/busy/stall cycles, measures per-transaction
// latency (last/min/max), flags protocol errors and freezes everything once
// finish has been sampled.
//
// Handshake: a transaction retires on a cycle where ap_done and ap_continue
// are both 1; ap_done with ap_continue low is a stall cycle. A start is
// accepted for counting when ap_start and ap_ready are both 1.
module nodf_module_intf
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] trans_cnt,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] last_lat,
    output logic [CNT_W-1:0] min_lat,
    output logic [CNT_W-1:0] max_lat,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             finished,
    output logic             proto_err
);

    localparam logic [63:0]      CNT_MAX = 64'({CNT_W{1'b1}});
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    mon_state_t       state_q;
    logic [CNT_W-1:0] lat_timer;

    logic             ret;
    logic             stall;
    logic             active;
    logic             record;
    logic [CNT_W-1:0] lat_inc;
    logic [CNT_W-1:0] rec_lat;
    logic [CNT_W-1:0] trans_nx;
    logic [CNT_W-1:0] start_nx;
    logic             err_idle_done;
    logic             err_count;

    assign state = state_q;

    // Retire/record decode and the post-update values used by the error check.
    always_comb begin
        ret           = ap_done & ap_continue;
        stall         = ap_done & ~ap_continue;
        active        = ~finished;
        lat_inc       = CNT_W'(sat_inc(64'(lat_timer), CNT_MAX));
        record        = 1'b0;
        rec_lat       = '0;
        case (state_q)
            IDLE: begin
                if (ap_start && ret) begin
                    record  = 1'b1;
                    rec_lat = ONE;
                end
            end
            RUN: begin
                if (ret) begin
                    record  = 1'b1;
                    rec_lat = lat_inc;
                end
            end
            DONE_WAIT: begin
                if (ap_continue) begin
                    record  = 1'b1;
                    rec_lat = lat_inc;
                end
            end
            default: begin
                record  = 1'b0;
                rec_lat = '0;
            end
        endcase
        trans_nx      = record ? CNT_W'(sat_inc(64'(trans_cnt), CNT_MAX)) : trans_cnt;
        start_nx      = (ap_start && ap_ready) ?
                        CNT_W'(sat_inc(64'(start_cnt), CNT_MAX)) : start_cnt;
        err_idle_done = (state_q == IDLE) && ap_done && !ap_start;
        err_count     = trans_nx > start_nx;
    end

    // Transaction FSM, latency timer, latency statistics, sticky flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_timer <= '0;
            last_lat  <= '0;
            min_lat   <= '1;
            max_lat   <= '0;
            finished  <= 1'b0;
            proto_err <= 1'b0;
        end else if (!finished) begin
            finished <= finish;
            case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        lat_timer <= ONE;
                        if (ret) begin
                            state_q <= IDLE;
                        end else if (stall) begin
                            state_q <= DONE_WAIT;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN, DONE_WAIT: begin
                    if ((state_q == RUN) ? ret : ap_continue) begin
                        if (ap_start) begin
                            state_q   <= RUN;
                            lat_timer <= ONE;
                        end else begin
                            state_q   <= IDLE;
                            lat_timer <= lat_inc;
                        end
                    end else begin
                        lat_timer <= lat_inc;
                        if (stall) begin
                            state_q <= DONE_WAIT;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (record) begin
                last_lat <= rec_lat;
                if (rec_lat < min_lat) begin
                    min_lat <= rec_lat;
                end
                if (rec_lat > max_lat) begin
                    max_lat <= rec_lat;
                end
            end
            if (err_idle_done || err_count) begin
                proto_err <= 1'b1;
            end
        end
    end

    nodf_sat_counter #(.CNT_W(CNT_W)) u_trans_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (active & record),
        .count (trans_cnt)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_start_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (active & ap_start & ap_ready),
        .count (start_cnt)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_busy_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (active & (state_q != IDLE)),
        .count (busy_cycles)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (active & stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_nodf_module_intf.sv
// Bench for nodf_module_intf: a per-cycle vector table for the main
// transaction flow plus hand-written idle, protocol-error and freeze sequences.
module tb_nodf_module_intf;

    localparam int          CNT_W = 32;
    localparam logic [31:0] ONES  = 32'hFFFF_FFFF;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             ap_start = 1'b0;
    logic             ap_ready = 1'b0;
    logic             ap_done = 1'b0;
    logic             ap_continue = 1'b0;
    logic             finish = 1'b0;
    logic [1:0]       state;
    logic [CNT_W-1:0] trans_cnt;
    logic [CNT_W-1:0] start_cnt;
    logic [CNT_W-1:0] last_lat;
    logic [CNT_W-1:0] min_lat;
    logic [CNT_W-1:0] max_lat;
    logic [CNT_W-1:0] busy_cycles;
    logic [CNT_W-1:0] stall_cycles;
    logic             finished;
    logic             proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        s, r, d, c;
        logic [1:0]  exp_state;
        logic [31:0] exp_trans;
        logic [31:0] exp_last;
        logic [31:0] exp_min;
        logic [31:0] exp_max;
    } vec_t;

    vec_t vecs[20];

    nodf_module_intf #(.CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .state        (state),
        .trans_cnt    (trans_cnt),
        .start_cnt    (start_cnt),
        .last_lat     (last_lat),
        .min_lat      (min_lat),
        .max_lat      (max_lat),
        .busy_cycles  (busy_cycles),
        .stall_cycles (stall_cycles),
        .finished     (finished),
        .proto_err    (proto_err)
    );

    // Clock and reset
    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Driver: apply one cycle of inputs at negedge, return just after the posedge.
    task automatic step(input logic s, input logic r, input logic d,
                        input logic c, input logic f);
        @(negedge clock);
        ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [31:0] tr,
                           input logic [31:0] sc, input logic [31:0] ll,
                           input logic [31:0] mn, input logic [31:0] mx,
                           input logic [31:0] bz, input logic [31:0] stl,
                           input logic fin, input logic pe);
        chk({tag, ".state"}, 64'(state), 64'(st));
        chk({tag, ".trans_cnt"}, 64'(trans_cnt), 64'(tr));
        chk({tag, ".start_cnt"}, 64'(start_cnt), 64'(sc));
        chk({tag, ".last_lat"}, 64'(last_lat), 64'(ll));
        chk({tag, ".min_lat"}, 64'(min_lat), 64'(mn));
        chk({tag, ".max_lat"}, 64'(max_lat), 64'(mx));
        chk({tag, ".busy_cycles"}, 64'(busy_cycles), 64'(bz));
        chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(stl));
        chk({tag, ".finished"}, 64'(finished), 64'(fin));
        chk({tag, ".proto_err"}, 64'(proto_err), 64'(pe));
    endtask

    initial begin
        // s r d c | state trans last min max
        // single transaction, latency 5
        vecs[0]  = '{1,1,0,1, 2'd1, 0, 0, ONES, 0};
        vecs[1]  = '{0,0,0,1, 2'd1, 0, 0, ONES, 0};
        vecs[2]  = '{0,0,0,1, 2'd1, 0, 0, ONES, 0};
        vecs[3]  = '{0,0,0,1, 2'd1, 0, 0, ONES, 0};
        vecs[4]  = '{0,0,1,1, 2'd0, 1, 5, 5, 5};
        // back-to-back: latency 5 then 2
        vecs[5]  = '{1,1,0,1, 2'd1, 1, 5, 5, 5};
        vecs[6]  = '{0,0,0,1, 2'd1, 1, 5, 5, 5};
        vecs[7]  = '{0,0,0,1, 2'd1, 1, 5, 5, 5};
        vecs[8]  = '{0,0,0,1, 2'd1, 1, 5, 5, 5};
        vecs[9]  = '{1,1,1,1, 2'd1, 2, 5, 5, 5};
        vecs[10] = '{0,0,1,1, 2'd0, 3, 2, 2, 5};
        // three stall cycles, latency 8 including stalls
        vecs[11] = '{1,1,0,1, 2'd1, 3, 2, 2, 5};
        vecs[12] = '{0,0,0,1, 2'd1, 3, 2, 2, 5};
        vecs[13] = '{0,0,0,1, 2'd1, 3, 2, 2, 5};
        vecs[14] = '{0,0,0,1, 2'd1, 3, 2, 2, 5};
        vecs[15] = '{0,0,1,0, 2'd2, 3, 2, 2, 5};
        vecs[16] = '{0,0,1,0, 2'd2, 3, 2, 2, 5};
        vecs[17] = '{0,0,1,0, 2'd2, 3, 2, 2, 5};
        vecs[18] = '{0,0,1,1, 2'd0, 4, 8, 2, 8};
        // start and retire in the same IDLE cycle: latency 1
        vecs[19] = '{1,1,1,1, 2'd0, 5, 1, 1, 8};

        // Test 1: reset values, then 50 idle cycles, then finish
        do_reset();
        #1;
        chk_all("reset", 2'd0, 0, 0, 0, ONES, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 0);
        chk_all("idle50", 2'd0, 0, 0, 0, ONES, 0, 0, 0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk_all("idle_fin", 2'd0, 0, 0, 0, ONES, 0, 0, 0, 1'b1, 1'b0);

        // Tests 2-4: vector table
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].s, vecs[i].r, vecs[i].d, vecs[i].c, 1'b0);
            chk($sformatf("v%0d.state", i), 64'(state), 64'(vecs[i].exp_state));
            chk($sformatf("v%0d.trans", i), 64'(trans_cnt), 64'(vecs[i].exp_trans));
            chk($sformatf("v%0d.last", i), 64'(last_lat), 64'(vecs[i].exp_last));
            chk($sformatf("v%0d.min", i), 64'(min_lat), 64'(vecs[i].exp_min));
            chk($sformatf("v%0d.max", i), 64'(max_lat), 64'(vecs[i].exp_max));
        end
        chk_all("table_end", 2'd0, 5, 5, 1, 1, 8, 16, 3, 1'b0, 1'b0);

        // Test 5: ap_done in IDLE without ap_start is sticky until reset
        do_reset();
        step(0, 0, 1, 1, 0);
        chk("perr_set", 64'(proto_err), 64'(1));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        chk_all("perr_hold", 2'd0, 0, 0, 0, ONES, 0, 0, 0, 1'b0, 1'b1);
        do_reset();
        #1;
        chk("perr_clr", 64'(proto_err), 64'(0));

        // Test 6: finish on the retire edge still records, then everything freezes
        do_reset();
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1);
        chk_all("fin_edge", 2'd0, 1, 1, 3, 3, 3, 2, 0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        chk_all("frozen", 2'd0, 1, 1, 3, 3, 3, 2, 0, 1'b1, 1'b0);
        do_reset();
        #1;
        chk_all("post_rst", 2'd0, 0, 0, 0, ONES, 0, 0, 0, 1'b0, 1'b0);

        // Frozen mid-transaction: state stays RUN, no busy growth
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        chk_all("frz_run", 2'd1, 0, 1, 0, ONES, 0, 1, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
